// File: rtl/regfile_port_sequencer.sv
// Shares the register file write port and rs2 read port between core writeback,
// a debug peek/poke port and a soft-clear sequencer that zeroes x1..x31.
module regfile_port_sequencer #(
  parameter int unsigned DBG_STARVE = 8
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        core_rs2_used,
  input  logic [4:0]  core_rs2_addr,
  output logic        core_stall,
  input  logic        dbg_req_valid,
  input  logic        dbg_req_write,
  input  logic [4:0]  dbg_req_addr,
  input  logic [31:0] dbg_req_wdata,
  output logic        dbg_req_ready,
  output logic        dbg_rsp_valid,
  output logic [31:0] dbg_rsp_rdata,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        clr_done,
  output logic        rf_we,
  output logic [4:0]  rf_addr_d,
  output logic [31:0] rf_data_d,
  output logic [4:0]  rf_addr_b,
  input  logic [31:0] rf_data_b
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;
  localparam logic [AW-1:0] CLR_FIRST = AW'(1);
  localparam logic [AW-1:0] CLR_LAST  = AW'(31);
  localparam logic [CW-1:0] STARVE_LIMIT = CW'(DBG_STARVE);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic            core_stall_q, core_stall_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            clr_busy_q, clr_busy_d;
  logic            clr_done_q, clr_done_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            dbg_accept;

  // Next-state, port steering and handshake.
  always_comb begin
    state_d       = state_q;
    core_stall_d  = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    clr_busy_d    = 1'b0;
    clr_done_d    = 1'b0;
    starve_d      = starve_q;
    clr_cnt_d     = clr_cnt_q;
    dbg_req_ready = 1'b0;
    dbg_accept    = 1'b0;
    rf_we         = 1'b0;
    rf_addr_d     = '0;
    rf_data_d     = '0;
    rf_addr_b     = core_rs2_addr;

    case (state_q)
      S_IDLE: begin
        // A core writing through a stall still owns the write port.
        if (!reset && !clr_start) begin
          if (dbg_req_write) dbg_req_ready = !wb_en;
          else               dbg_req_ready = !core_rs2_used || core_stall_q;
        end
        dbg_accept = dbg_req_valid && dbg_req_ready;

        if (wb_en) begin
          rf_we     = 1'b1;
          rf_addr_d = wb_addr;
          rf_data_d = wb_data;
        end else if (dbg_accept && dbg_req_write) begin
          rf_we     = 1'b1;
          rf_addr_d = dbg_req_addr;
          rf_data_d = dbg_req_wdata;
        end

        if (dbg_accept && !dbg_req_write) rf_addr_b = dbg_req_addr;

        if (dbg_accept) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = dbg_req_write ? '0 : rf_data_b;
        end

        if (dbg_accept || !dbg_req_valid) begin
          starve_d = '0;
        end else begin
          starve_d     = starve_q + CW'(1);
          core_stall_d = (starve_d == STARVE_LIMIT);
        end

        if (clr_start) begin
          state_d      = S_CLEAR;
          clr_cnt_d    = CLR_FIRST;
          core_stall_d = 1'b1;
          clr_busy_d   = 1'b1;
        end
      end

      S_CLEAR: begin
        rf_we     = 1'b1;
        rf_addr_d = clr_cnt_q;
        rf_data_d = '0;
        starve_d  = '0;
        if (clr_cnt_q == CLR_LAST) begin
          state_d    = S_IDLE;
          clr_cnt_d  = CLR_FIRST;
          clr_done_d = 1'b1;
        end else begin
          clr_cnt_d    = clr_cnt_q + AW'(1);
          core_stall_d = 1'b1;
          clr_busy_d   = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Reset aborts a clear immediately, so no write may land in the reset cycle.
    if (reset) rf_we = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      core_stall_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      clr_busy_q   <= 1'b0;
      clr_done_q   <= 1'b0;
      starve_q     <= '0;
      clr_cnt_q    <= CLR_FIRST;
    end else begin
      state_q      <= state_d;
      core_stall_q <= core_stall_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      clr_busy_q   <= clr_busy_d;
      clr_done_q   <= clr_done_d;
      starve_q     <= starve_d;
      clr_cnt_q    <= clr_cnt_d;
    end
  end

  assign core_stall    = core_stall_q;
  assign dbg_rsp_valid = rsp_valid_q;
  assign dbg_rsp_rdata = rsp_rdata_q;
  assign clr_busy      = clr_busy_q;
  assign clr_done      = clr_done_q;

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Bench for regfile_port_sequencer: directed scenarios plus random traffic against a
// cycle reference model, with debug responses checked through a scoreboard queue.
module tb_regfile_port_sequencer;

  localparam int DBG_STARVE = 8;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        core_rs2_used = 1'b0;
  logic [4:0]  core_rs2_addr = '0;
  logic        core_stall;
  logic        dbg_req_valid = 1'b0;
  logic        dbg_req_write = 1'b0;
  logic [4:0]  dbg_req_addr = '0;
  logic [31:0] dbg_req_wdata = '0;
  logic        dbg_req_ready;
  logic        dbg_rsp_valid;
  logic [31:0] dbg_rsp_rdata;
  logic        clr_start = 1'b0;
  logic        clr_busy;
  logic        clr_done;
  logic        rf_we;
  logic [4:0]  rf_addr_d;
  logic [31:0] rf_data_d;
  logic [4:0]  rf_addr_b;
  logic [31:0] rf_data_b;

  regfile_port_sequencer #(.DBG_STARVE(DBG_STARVE)) dut (
    .Clk(Clk), .reset(reset),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .core_rs2_used(core_rs2_used), .core_rs2_addr(core_rs2_addr), .core_stall(core_stall),
    .dbg_req_valid(dbg_req_valid), .dbg_req_write(dbg_req_write), .dbg_req_addr(dbg_req_addr),
    .dbg_req_wdata(dbg_req_wdata), .dbg_req_ready(dbg_req_ready),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_rdata(dbg_rsp_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .rf_we(rf_we), .rf_addr_d(rf_addr_d), .rf_data_d(rf_data_d),
    .rf_addr_b(rf_addr_b), .rf_data_b(rf_data_b)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  always @(posedge Clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Register file attached to the DUT ports (x0 reads zero).
  logic [31:0] rf_mem [32];
  always @(posedge Clk) if (rf_we && rf_addr_d != 5'd0) rf_mem[rf_addr_d] <= rf_data_d;
  assign rf_data_b = rf_mem[rf_addr_b];

  // Reference model state.
  typedef struct { int cyc; logic [31:0] data; } rsp_t;
  rsp_t        sb[$];
  logic [31:0] m_rf [32];
  bit          m_clear = 0, m_stall = 0, m_done = 0;
  int          m_idx = 1, m_starve = 0;
  bit          n_reset = 1, n_clear = 0, n_stall = 0, n_done = 0, n_we = 0;
  int          n_idx = 1, n_starve = 0, n_waddr = 0;
  logic [31:0] n_wdata = '0;

  initial for (int i = 0; i < 32; i++) begin rf_mem[i] = '0; m_rf[i] = '0; end

  // Model: expected outputs this cycle, and the state after the coming edge.
  always @(negedge Clk) begin : model_chk
    bit exp_ready, acc, e_we;
    int e_addr;
    logic [31:0] e_data;
    exp_ready = 0; acc = 0; e_we = 0; e_addr = 0; e_data = '0;
    if (reset) begin
      n_reset = 1; n_we = 0;
    end else begin
      n_reset = 0;
      if (m_clear || clr_start) exp_ready = 0;
      else if (dbg_req_write)   exp_ready = !wb_en;
      else                      exp_ready = !core_rs2_used || m_stall;
      acc = dbg_req_valid && exp_ready;
      if (m_clear)                   begin e_we = 1; e_addr = m_idx; e_data = '0; end
      else if (wb_en)                begin e_we = 1; e_addr = wb_addr; e_data = wb_data; end
      else if (acc && dbg_req_write) begin e_we = 1; e_addr = dbg_req_addr; e_data = dbg_req_wdata; end
      if (!m_clear) chk("rf_addr_b", 32'(rf_addr_b), (acc && !dbg_req_write) ? 32'(dbg_req_addr) : 32'(core_rs2_addr));
      if (acc) sb.push_back('{cyc_n, dbg_req_write ? 32'd0 : m_rf[dbg_req_addr]});
      if (!m_clear) begin
        if (dbg_req_valid && !acc) begin
          n_starve = (m_starve + 1) % 256;
          n_stall  = (n_starve == DBG_STARVE);
        end else begin
          n_starve = 0; n_stall = 0;
        end
        n_done = 0; n_clear = 0; n_idx = m_idx;
        if (clr_start) begin n_clear = 1; n_idx = 1; n_stall = 1; end
      end else begin
        n_starve = 0;
        if (m_idx == 31) begin n_clear = 0; n_idx = 1; n_done = 1; n_stall = 0; end
        else             begin n_clear = 1; n_idx = m_idx + 1; n_done = 0; n_stall = 1; end
      end
      n_we = e_we; n_waddr = e_addr; n_wdata = e_data;
    end
    chk("rf_we", 32'(rf_we), 32'(e_we));
    if (e_we) begin
      chk("rf_addr_d", 32'(rf_addr_d), 32'(e_addr));
      chk("rf_data_d", rf_data_d, e_data);
    end
    if (dbg_req_valid) chk("dbg_req_ready", 32'(dbg_req_ready), 32'(exp_ready));
    chk("core_stall", 32'(core_stall), 32'(m_stall));
    chk("clr_busy", 32'(clr_busy), 32'(m_clear));
    chk("clr_done", 32'(clr_done), 32'(m_done));
  end

  always @(posedge Clk) begin : model_commit
    if (n_reset) begin
      m_clear = 0; m_stall = 0; m_done = 0; m_idx = 1; m_starve = 0;
      sb.delete();
    end else begin
      if (n_we && n_waddr != 0) m_rf[n_waddr] = n_wdata;
      m_clear = n_clear; m_stall = n_stall; m_done = n_done; m_idx = n_idx; m_starve = n_starve;
    end
  end

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  logic [31:0] mon_last = '0;
  bit          mon_prev_reset = 1;
  always @(negedge Clk) begin : rsp_monitor
    rsp_t e;
    if (mon_prev_reset) mon_last = '0;
    while (sb.size() > 0 && sb[0].cyc < cyc_n - 1) begin
      e = sb.pop_front();
      chk("missing dbg response", 32'(dbg_rsp_valid), 32'd1);
    end
    if (dbg_rsp_valid) begin
      if (sb.size() == 0 || sb[0].cyc != cyc_n - 1) begin
        chk("unexpected dbg response", 32'(dbg_rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("dbg_rsp_rdata", dbg_rsp_rdata, e.data);
        mon_last = e.data;
      end
    end else begin
      chk("dbg_rsp_rdata hold", dbg_rsp_rdata, mon_last);
    end
    mon_prev_reset = reset;
  end

  // Core side: honours the stall contract.
  bit want_wb = 0, want_rs2 = 0;
  task automatic apply_core();
    wb_en         = want_wb && !core_stall;
    core_rs2_used = want_rs2 && !core_stall;
  endtask

  task automatic cyc();
    @(posedge Clk); #1;
    apply_core();
  endtask

  task automatic dbg_op(input bit wr, input logic [4:0] a, input logic [31:0] d,
                        output int waited, output bit stall_at, output logic [4:0] ab_at,
                        output bit ab_wait_bad);
    bit got;
    got = 0; waited = 0; stall_at = 0; ab_at = '0; ab_wait_bad = 0;
    apply_core();
    dbg_req_valid = 1; dbg_req_write = wr; dbg_req_addr = a; dbg_req_wdata = d;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge Clk);
      if (dbg_req_ready) begin
        got = 1; stall_at = core_stall; ab_at = rf_addr_b;
      end else begin
        waited++;
        if (rf_addr_b !== core_rs2_addr) ab_wait_bad = 1;
      end
      cyc();
    end
    dbg_req_valid = 0;
    chk("dbg accept within bound", 32'(got), 32'd1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin : stim
    int waited, busy_n, done_at, exp_a, acc_k, dummy_w;
    bit stall_at, ab_bad, order_bad, got, done_acc, found, accepted;
    logic [4:0] ab_at;
    logic [31:0] v11;

    repeat (3) cyc();
    reset = 0;
    @(negedge Clk);
    chk("reset core_stall", 32'(core_stall), 32'd0);
    chk("reset dbg_rsp_valid", 32'(dbg_rsp_valid), 32'd0);
    chk("reset dbg_rsp_rdata", dbg_rsp_rdata, 32'd0);
    chk("reset clr_busy", 32'(clr_busy), 32'd0);
    chk("reset clr_done", 32'(clr_done), 32'd0);
    cyc();

    // Writeback vs. debug write contention until starvation stall.
    want_wb = 1; wb_addr = 5'd5; wb_data = 32'h11;
    dbg_op(1, 5'd6, 32'h22, waited, stall_at, ab_at, ab_bad);
    chk("starve ready-low cycles", 32'(waited), 32'd8);
    chk("starve accept under stall", 32'(stall_at), 32'd1);
    chk("starve rsp_valid after accept", 32'(dbg_rsp_valid), 32'd1);
    want_wb = 0; apply_core();
    repeat (2) cyc();
    chk("x5 written by core", rf_mem[5], 32'h11);
    chk("x6 written by debug", rf_mem[6], 32'h22);

    // Debug read with free rs2 port.
    dbg_op(1, 5'd7, 32'hDEADBEEF, waited, stall_at, ab_at, ab_bad);
    dbg_op(0, 5'd7, 32'h0, waited, stall_at, ab_at, ab_bad);
    chk("read rf_addr_b at accept", 32'(ab_at), 32'd7);
    chk("read rsp_valid", 32'(dbg_rsp_valid), 32'd1);
    chk("read rsp_rdata", dbg_rsp_rdata, 32'hDEADBEEF);

    // Read contention with the core rs2 port.
    dbg_op(1, 5'd9, 32'h9999, waited, stall_at, ab_at, ab_bad);
    want_rs2 = 1; core_rs2_addr = 5'd3;
    dbg_op(0, 5'd9, 32'h0, waited, stall_at, ab_at, ab_bad);
    chk("rs2 contention wait", 32'(waited), 32'd8);
    chk("rs2 core address while waiting", 32'(ab_bad), 32'd0);
    chk("rs2 debug address at stall", 32'(ab_at), 32'd9);
    chk("rs2 accept under stall", 32'(stall_at), 32'd1);
    want_rs2 = 0; apply_core();
    cyc();

    // Soft clear of a fully loaded file.
    for (int i = 1; i < 32; i++) dbg_op(1, 5'(i), ($urandom() | 32'h1), waited, stall_at, ab_at, ab_bad);
    clr_start = 1; cyc(); clr_start = 0;
    busy_n = 0; done_at = 0; exp_a = 1; order_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge Clk);
      if (clr_busy) busy_n++;
      if (clr_done && done_at == 0) done_at = k;
      if (clr_busy && rf_we) begin
        if (rf_addr_d !== 5'(exp_a) || rf_data_d !== 32'd0) order_bad = 1;
        exp_a++;
      end
      cyc();
    end
    chk("clear busy cycles", 32'(busy_n), 32'd31);
    chk("clear done cycle", 32'(done_at), 32'd32);
    chk("clear write order", 32'(order_bad), 32'd0);
    chk("clear write count", 32'(exp_a), 32'd32);
    for (int i = 1; i < 32; i++) begin
      dbg_op(0, 5'(i), 32'h0, waited, stall_at, ab_at, ab_bad);
      if (i % 8 == 1) chk("cleared reg reads zero", dbg_rsp_rdata, 32'd0);
    end

    // Clear start colliding with a debug write.
    dbg_req_valid = 1; dbg_req_write = 1; dbg_req_addr = 5'd12; dbg_req_wdata = 32'h55;
    clr_start = 1;
    got = 0; acc_k = -1; done_acc = 0;
    for (int k = 0; k <= 50 && !got; k++) begin
      @(negedge Clk);
      if (dbg_req_ready) begin got = 1; acc_k = k; done_acc = clr_done; end
      cyc();
      clr_start = 0;
    end
    dbg_req_valid = 0;
    chk("collision accept cycle", 32'(acc_k), 32'd32);
    chk("collision accept with clr_done", 32'(done_acc), 32'd1);
    cyc();

    // Reset in the middle of a clear.
    for (int i = 10; i < 16; i++) dbg_op(1, 5'(i), 32'hA000 + 32'(i), waited, stall_at, ab_at, ab_bad);
    v11 = 32'hA000 + 32'd11;
    clr_start = 1; cyc(); clr_start = 0;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge Clk);
      if (clr_busy && rf_we && rf_addr_d == 5'd10) found = 1;
      cyc();
    end
    chk("x10 clear write seen", 32'(found), 32'd1);
    reset = 1;
    @(negedge Clk);
    chk("no write in reset cycle", 32'(rf_we), 32'd0);
    cyc();
    reset = 0;
    @(negedge Clk);
    chk("abort core_stall", 32'(core_stall), 32'd0);
    chk("abort clr_busy", 32'(clr_busy), 32'd0);
    chk("abort clr_done", 32'(clr_done), 32'd0);
    chk("abort rsp_valid", 32'(dbg_rsp_valid), 32'd0);
    chk("abort rsp_rdata", dbg_rsp_rdata, 32'd0);
    done_at = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      @(negedge Clk);
      if (clr_done) done_at++;
    end
    chk("no clr_done after abort", 32'(done_at), 32'd0);
    chk("x10 cleared before abort", rf_mem[10], 32'd0);
    chk("x11 kept after abort", rf_mem[11], v11);
    cyc();

    // Random traffic.
    accepted = 1;
    for (int i = 0; i < 500; i++) begin
      want_wb = ($urandom_range(0, 2) == 0);
      wb_addr = 5'($urandom_range(0, 31));
      wb_data = $urandom();
      want_rs2 = ($urandom_range(0, 1) == 1);
      core_rs2_addr = 5'($urandom_range(0, 31));
      if (!dbg_req_valid || accepted) begin
        dbg_req_valid = ($urandom_range(0, 1) == 1);
        dbg_req_write = ($urandom_range(0, 1) == 1);
        dbg_req_addr  = 5'($urandom_range(0, 31));
        dbg_req_wdata = $urandom();
      end
      clr_start = ($urandom_range(0, 79) == 0);
      apply_core();
      @(negedge Clk);
      accepted = dbg_req_valid && dbg_req_ready;
      @(posedge Clk); #1;
    end
    want_wb = 0; want_rs2 = 0; dbg_req_valid = 0; clr_start = 0;
    apply_core();
    for (int k = 0; k < 40 && clr_busy; k++) cyc();
    repeat (4) cyc();

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    for (int i = 0; i < 32; i++) chk("regfile contents", rf_mem[i], m_rf[i]);
    dummy_w = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
